// File: rtl/fpu_share_arbiter_pkg.sv
// Shared constants and types for the FPU share arbiter: opcodes, response flag codes
// and the arbiter state encoding.
package fpu_share_arbiter_pkg;

    localparam logic [1:0] FPU_OP_ADD = 2'd0;
    localparam logic [1:0] FPU_OP_SUB = 2'd1;
    localparam logic [1:0] FPU_OP_MUL = 2'd2;

    localparam logic [1:0] OFUF_OK  = 2'b00;
    localparam logic [1:0] OFUF_OF  = 2'b10;
    localparam logic [1:0] OFUF_UF  = 2'b01;
    localparam logic [1:0] OFUF_TMO = 2'b11;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/fpu_share_arbiter_if.sv
// Client and FPU-facing signal bundle of the FPU share arbiter.
// req is a level held with stable operands until the one-cycle gnt pulse (operands captured);
// rsp_valid is a one-cycle pulse to the owning client with no back-pressure.
interface fpu_share_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import fpu_share_arbiter_pkg::*;

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] req_x;
    logic [NUM_REQ*16-1:0] req_y;
    logic [NUM_REQ*2-1:0]  req_op;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [15:0]           rsp_result;
    logic [1:0]            rsp_ofuf;
    logic [2:0]            rsp_comp;
    logic                  busy;
    logic [15:0]           fpu_x;
    logic [15:0]           fpu_y;
    logic [1:0]            fpu_opcode;
    logic                  fpu_start;
    logic                  fpu_done;
    logic [15:0]           fpu_result;
    logic [1:0]            fpu_ofuf;
    logic [2:0]            fpu_comp;
    arb_state_t            dbg_state;

    modport master (
        output req, req_x, req_y, req_op,
        output fpu_done, fpu_result, fpu_ofuf, fpu_comp,
        input  gnt, rsp_valid, rsp_result, rsp_ofuf, rsp_comp, busy,
        input  fpu_x, fpu_y, fpu_opcode, fpu_start, dbg_state
    );

    modport slave (
        input  req, req_x, req_y, req_op,
        input  fpu_done, fpu_result, fpu_ofuf, fpu_comp,
        output gnt, rsp_valid, rsp_result, rsp_ofuf, rsp_comp, busy,
        output fpu_x, fpu_y, fpu_opcode, fpu_start, dbg_state
    );

endinterface

// File: rtl/fpu_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from the pointer, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt_oh = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_gnt_oh[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU among NUM_REQ clients: round-robin grant, operand capture, FPU start pulse,
// done wait with timeout, and a one-cycle response to the winning client.
module fpu_share_arbiter
    import fpu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    fpu_share_arbiter_if.slave bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [IW-1:0]        r_ptr;
    logic [NUM_REQ-1:0]   r_win_oh;
    logic [TIMER_W-1:0]   r_timer;
    logic [15:0]          r_fpu_x;
    logic [15:0]          r_fpu_y;
    logic [1:0]           r_fpu_op;
    logic [15:0]          r_rsp_result;
    logic [1:0]           r_rsp_ofuf;
    logic [2:0]           r_rsp_comp;

    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_pick_any;
    logic                 w_launch;
    logic                 w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_gnt_oh (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // RESP re-arbitrates in the same cycle, so back-to-back ops see no IDLE bubble.
    assign w_launch  = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && w_pick_any;
    assign w_timeout = (r_timer == TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_pick_any) w_next_state = ST_LAUNCH;
            ST_LAUNCH: w_next_state = ST_ARM;
            ST_ARM:    w_next_state = ST_WAIT;
            ST_WAIT:   if (bus.fpu_done || w_timeout) w_next_state = ST_RESP;
            ST_RESP:   w_next_state = w_pick_any ? ST_LAUNCH : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.fpu_start = 1'b0;
        bus.busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_LAUNCH: begin
                bus.gnt       = r_win_oh;
                bus.fpu_start = 1'b1;
            end
            ST_RESP:   bus.rsp_valid = r_win_oh;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_win_oh     <= '0;
            r_timer      <= '0;
            r_fpu_x      <= '0;
            r_fpu_y      <= '0;
            r_fpu_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_ofuf   <= OFUF_OK;
            r_rsp_comp   <= '0;
        end else begin
            if (w_launch) begin
                r_win_oh <= w_pick_oh;
                r_ptr    <= (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : IW'(w_pick_idx + 1'b1);
                r_fpu_x  <= bus.req_x[{w_pick_idx, 4'b0000} +: 16];
                r_fpu_y  <= bus.req_y[{w_pick_idx, 4'b0000} +: 16];
                r_fpu_op <= bus.req_op[{w_pick_idx, 1'b0} +: 2];
            end
            if (r_state == ST_ARM) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT && !bus.fpu_done && !w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end
            // done is checked before expiry so a late-but-valid result still wins.
            if (r_state == ST_WAIT) begin
                if (bus.fpu_done) begin
                    r_rsp_result <= bus.fpu_result;
                    r_rsp_ofuf   <= bus.fpu_ofuf;
                    r_rsp_comp   <= bus.fpu_comp;
                end else if (w_timeout) begin
                    r_rsp_result <= '0;
                    r_rsp_ofuf   <= OFUF_TMO;
                    r_rsp_comp   <= '0;
                end
            end
        end
    end

    assign bus.fpu_x      = r_fpu_x;
    assign bus.fpu_y      = r_fpu_y;
    assign bus.fpu_opcode = r_fpu_op;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_ofuf   = r_rsp_ofuf;
    assign bus.rsp_comp   = r_rsp_comp;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: two clients, a delay-programmable FPU model, a cycle-level
// reference model compared every cycle, and directed latency/value checks.
module tb_fpu_share_arbiter;
    import fpu_share_arbiter_pkg::*;

    localparam int NR  = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

    fpu_share_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // client drive
    logic [NR-1:0] creq = '0;
    logic [15:0] cx0 = '0, cx1 = '0, cy0 = '0, cy1 = '0;
    logic [1:0]  cop0 = '0, cop1 = '0;
    assign bus.req    = creq;
    assign bus.req_x  = {cx1, cx0};
    assign bus.req_y  = {cy1, cy0};
    assign bus.req_op = {cop1, cop0};

    // FPU model: done rises fpu_d cycles after start falls and stays high until the next start
    int   fpu_d = 3;
    bit   stale_mode = 1'b0;
    bit   never_mode = 1'b0;
    int   fcnt = 0;
    bit   frun = 1'b0;
    logic start_q = 1'b0;
    logic fdone = 1'b0;
    logic [15:0] fres = '0;
    logic [1:0]  fofuf = '0;
    logic [2:0]  fcomp = '0;
    assign bus.fpu_done   = fdone;
    assign bus.fpu_result = fres;
    assign bus.fpu_ofuf   = fofuf;
    assign bus.fpu_comp   = fcomp;

    always @(negedge clk) start_q = bus.fpu_start;
    always @(posedge clk) begin
        if (start_q) begin
            fcnt = 0;
            frun = 1'b1;
            if (!stale_mode) fdone <= 1'b0;
        end else if (frun) begin
            fcnt++;
            if (stale_mode && fcnt == 1) fdone <= 1'b0;
            if (!never_mode && fcnt == fpu_d + (stale_mode ? 1 : 0)) fdone <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // observation log for directed checks
    int gnt_cyc0 = -1, gnt_cyc1 = -1, rsp_cyc0 = -1, rsp_cyc1 = -1;
    int rsp_cnt = 0;
    logic [15:0] last_res = '0;
    logic [1:0]  last_ofuf = '0;
    logic [2:0]  last_comp = '0;

    // reference model: m_age counts cycles since the grant; WAIT begins at age 2
    bit m_on = 1'b0, m_act = 1'b0, m_resp = 1'b0;
    int m_age = 0, m_owner = 0, m_rowner = 0, m_ptr = 0;
    logic [15:0] m_fx = '0, m_fy = '0, m_rres = '0;
    logic [1:0]  m_fop = '0, m_rofuf = '0;
    logic [2:0]  m_rcomp = '0;
    logic [NR-1:0] g_seen = '0;

    function automatic int rr_pick(logic [NR-1:0] r, int p);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (p + k) % NR;
            if (((r >> idx) & NR'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [NR-1:0] eg, er;
        logic eb, es;
        bit ok;
        int w;
        if (bus.gnt[0] === 1'b1) gnt_cyc0 = cyc;
        if (bus.gnt[1] === 1'b1) gnt_cyc1 = cyc;
        if (bus.rsp_valid[0] === 1'b1) rsp_cyc0 = cyc;
        if (bus.rsp_valid[1] === 1'b1) rsp_cyc1 = cyc;
        if (bus.rsp_valid !== '0) begin
            rsp_cnt++;
            last_res  = bus.rsp_result;
            last_ofuf = bus.rsp_ofuf;
            last_comp = bus.rsp_comp;
        end
        if (m_on) begin
            eg = (m_act && m_age == 0) ? (NR'(1) << m_owner) : '0;
            er = m_resp ? (NR'(1) << m_rowner) : '0;
            eb = m_act || m_resp;
            es = m_act && m_age == 0;
            ok = (bus.gnt === eg) && (bus.rsp_valid === er) && (bus.busy === eb) &&
                 (bus.fpu_start === es) && (bus.fpu_x === m_fx) && (bus.fpu_y === m_fy) &&
                 (bus.fpu_opcode === m_fop);
            if (m_resp)
                ok = ok && (bus.rsp_result === m_rres) && (bus.rsp_ofuf === m_rofuf) &&
                     (bus.rsp_comp === m_rcomp);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL model cyc=%0d gnt=%b exp %b rsp_valid=%b exp %b busy=%b exp %b start=%b exp %b x=%h exp %h y=%h exp %h op=%h exp %h res=%h exp %h ofuf=%b exp %b",
                         cyc, bus.gnt, eg, bus.rsp_valid, er, bus.busy, eb, bus.fpu_start, es,
                         bus.fpu_x, m_fx, bus.fpu_y, m_fy, bus.fpu_opcode, m_fop,
                         bus.rsp_result, m_rres, bus.rsp_ofuf, m_rofuf);
            end
        end
        if (reset) begin
            m_on = 1'b1; m_act = 1'b0; m_resp = 1'b0; m_age = 0; m_ptr = 0;
            m_fx = '0; m_fy = '0; m_fop = '0;
        end else if (m_on) begin
            m_resp = 1'b0;
            if (m_act) begin
                if (m_age >= 2 && bus.fpu_done === 1'b1) begin
                    m_resp = 1'b1; m_rowner = m_owner; m_act = 1'b0;
                    m_rres = bus.fpu_result; m_rofuf = bus.fpu_ofuf; m_rcomp = bus.fpu_comp;
                end else if (m_age == TMO + 1) begin
                    m_resp = 1'b1; m_rowner = m_owner; m_act = 1'b0;
                    m_rres = '0; m_rofuf = OFUF_TMO; m_rcomp = '0;
                end else begin
                    m_age++;
                end
            end else begin
                w = rr_pick(bus.req, m_ptr);
                if (w >= 0) begin
                    m_act = 1'b1; m_age = 0; m_owner = w; m_ptr = (w + 1) % NR;
                    m_fx  = 16'(bus.req_x >> (w * 16));
                    m_fy  = 16'(bus.req_y >> (w * 16));
                    m_fop = 2'(bus.req_op >> (w * 2));
                end
            end
        end
    endtask

    // one clock: model check at negedge, then drop req of any client granted this cycle
    task automatic tick();
        @(negedge clk);
        model_step();
        g_seen = bus.gnt;
        @(posedge clk);
        #1;
        creq = creq & ~g_seen;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic set_client(int i, logic [15:0] x, logic [15:0] y, logic [1:0] op);
        if (i == 0) begin
            cx0 = x; cy0 = y; cop0 = op; creq[0] = 1'b1;
        end else begin
            cx1 = x; cy1 = y; cop1 = op; creq[1] = 1'b1;
        end
    endtask

    task automatic wait_rsp(int target, string name);
        int k;
        k = 0;
        while (rsp_cnt < target && k < 100) begin
            tick();
            k++;
        end
        chk(name, 32'(rsp_cnt), 32'(target));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int c0;
    int r0;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_ctrl", 32'({bus.gnt, bus.rsp_valid, bus.busy, bus.fpu_start}), 32'h0);
        chk("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("reset_rsp", 32'({bus.rsp_result, bus.rsp_ofuf, bus.rsp_comp}), 32'h0);

        // 1: single multiply 1.0 * 2.0
        fres = 16'h4000; fofuf = OFUF_OK; fcomp = 3'b001;
        c0 = cyc;
        set_client(0, 16'h3C00, 16'h4000, FPU_OP_MUL);
        wait_rsp(1, "t1_rsp_arrived");
        chk("t1_gnt_cycle", 32'(gnt_cyc0 - c0), 32'd1);
        chk("t1_rsp_cycle", 32'(rsp_cyc0 - c0), 32'd6);
        chk("t1_result", 32'(last_res), 32'h4000);
        chk("t1_ofuf", 32'(last_ofuf), 32'(OFUF_OK));
        chk("t1_fpu_operands", 32'({bus.fpu_x, bus.fpu_y[15:8], 6'd0, bus.fpu_opcode}), 32'h3C00_4002);

        // 2: contention from reset, then pointer-driven order
        do_reset();
        fres = 16'h1111; fcomp = 3'b100;
        c0 = cyc;
        set_client(0, 16'h0101, 16'h0202, FPU_OP_ADD);
        set_client(1, 16'h0303, 16'h0404, FPU_OP_SUB);
        wait_rsp(3, "t2_pair_arrived");
        chk("t2_gnt0_cycle", 32'(gnt_cyc0 - c0), 32'd1);
        chk("t2_rsp0_cycle", 32'(rsp_cyc0 - c0), 32'd6);
        chk("t2_gnt1_cycle", 32'(gnt_cyc1 - c0), 32'd7);
        chk("t2_rsp1_cycle", 32'(rsp_cyc1 - c0), 32'd12);
        c0 = cyc;
        set_client(0, 16'h0505, 16'h0606, FPU_OP_MUL);
        set_client(1, 16'h0707, 16'h0808, FPU_OP_ADD);
        wait_rsp(5, "t2_again_arrived");
        chk("t2_again_gnt0", 32'(gnt_cyc0 - c0), 32'd1);
        chk("t2_again_gnt1", 32'(gnt_cyc1 - c0), 32'd7);
        set_client(0, 16'h0909, 16'h0A0A, FPU_OP_ADD);
        wait_rsp(6, "t2_single_arrived");
        c0 = cyc;
        set_client(0, 16'h0B0B, 16'h0C0C, FPU_OP_SUB);
        set_client(1, 16'h0D0D, 16'h0E0E, FPU_OP_MUL);
        wait_rsp(8, "t2_rr_arrived");
        chk("t2_rr_gnt1_first", 32'(gnt_cyc1 - c0), 32'd1);
        chk("t2_rr_gnt0_second", 32'(gnt_cyc0 - c0), 32'd7);

        // 3: stale done held through LAUNCH/ARM, low for three WAIT cycles
        stale_mode = 1'b1; fres = 16'h2222; fcomp = 3'b010;
        c0 = cyc;
        set_client(0, 16'h1234, 16'h4321, FPU_OP_ADD);
        wait_rsp(9, "t3_rsp_arrived");
        chk("t3_rsp_cycle", 32'(rsp_cyc0 - c0), 32'd7);
        chk("t3_result", 32'(last_res), 32'h2222);
        stale_mode = 1'b0;

        // 4: timeout, then done arriving in the expiry cycle
        never_mode = 1'b1; fres = 16'hABCD; fofuf = OFUF_OF;
        c0 = cyc;
        set_client(1, 16'h5555, 16'h6666, FPU_OP_MUL);
        wait_rsp(10, "t4_rsp_arrived");
        chk("t4_rsp_cycle", 32'(rsp_cyc1 - c0), 32'd11);
        chk("t4_tmo_result", 32'({last_res, last_ofuf}), 32'({16'h0000, OFUF_TMO}));
        chk("t4_idle_after", 32'({bus.busy, bus.dbg_state}), 32'({1'b0, ST_IDLE}));
        never_mode = 1'b0;
        fpu_d = 8; fres = 16'h0001; fofuf = OFUF_UF;
        c0 = cyc;
        set_client(0, 16'h0400, 16'h0400, FPU_OP_MUL);
        wait_rsp(11, "t4_edge_arrived");
        chk("t4_edge_cycle", 32'(rsp_cyc0 - c0), 32'd11);
        chk("t4_done_wins", 32'({last_res, last_ofuf}), 32'({16'h0001, OFUF_UF}));
        fpu_d = 3;

        // 5: subtract and overflow pass-through
        fres = 16'h3C00; fofuf = OFUF_OK; fcomp = 3'b001;
        set_client(1, 16'h3E00, 16'h3800, FPU_OP_SUB);
        wait_rsp(12, "t5_sub_arrived");
        chk("t5_sub_result", 32'({last_res, last_ofuf}), 32'({16'h3C00, OFUF_OK}));
        chk("t5_sub_opcode", 32'({bus.fpu_x, bus.fpu_opcode}), 32'({16'h3E00, FPU_OP_SUB}));
        fres = 16'h7C00; fofuf = OFUF_OF; fcomp = 3'b001;
        set_client(0, 16'h7BFF, 16'h7BFF, FPU_OP_MUL);
        wait_rsp(13, "t5_ovf_arrived");
        chk("t5_ovf_ofuf", 32'({last_res, last_ofuf}), 32'({16'h7C00, OFUF_OF}));

        // 6: reset during WAIT abandons the op
        fres = 16'h4444; fofuf = OFUF_OK; fcomp = 3'b100;
        set_client(1, 16'h1357, 16'h2468, FPU_OP_ADD);
        ticks(4);
        chk("t6_in_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
        r0 = rsp_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_reset_ctrl", 32'({bus.gnt, bus.rsp_valid, bus.busy, bus.fpu_start}), 32'h0);
        chk("t6_reset_fpu", 32'({bus.fpu_x, bus.fpu_y}), 32'h0);
        chk("t6_reset_op_rsp", 32'({bus.fpu_opcode, bus.rsp_result, bus.rsp_ofuf}), 32'h0);
        ticks(10);
        chk("t6_no_rsp", 32'(rsp_cnt), 32'(r0));
        c0 = cyc;
        set_client(1, 16'h1111, 16'h2222, FPU_OP_ADD);
        wait_rsp(r0 + 1, "t6_fresh_arrived");
        chk("t6_fresh_cycle", 32'(rsp_cyc1 - c0), 32'd6);
        chk("t6_fresh_result", 32'(last_res), 32'h4444);
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
